// File: rtl/sync32_reg_arbiter_if.sv
// Requester-side bus for sync32_reg_arbiter: per-requester req/word and the shared register outputs.
// Define SYNC32_ARB_LOCK_EN to add the per-requester lock signal.
interface sync32_reg_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] wr_data;
`ifdef SYNC32_ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        ack;
    logic [IDX_W-1:0]       owner;
    logic                   busy;
    logic [DATA_W-1:0]      OutData;

`ifdef SYNC32_ARB_LOCK_EN
    modport master (output req, wr_data, lock, input grant, ack, owner, busy, OutData);
    modport slave  (input req, wr_data, lock, output grant, ack, owner, busy, OutData);
`else
    modport master (output req, wr_data, input grant, ack, owner, busy, OutData);
    modport slave  (input req, wr_data, output grant, ack, owner, busy, OutData);
`endif
endinterface

// File: rtl/sync32_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared DATA_W register.
// Optional SYNC32_ARB_LOCK_EN lets the owner keep the grant and write every cycle while lock is held.
module sync32_reg_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sync32_reg_arbiter_if.slave  bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SYNC32_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, ACK, LOCKED} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
`endif

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [IDX_W-1:0]  win;
    logic              found;
    logic [IDX_W-1:0]  idx_w;
    int unsigned       idx;
    logic [IDX_W-1:0]  owner_nxt;
    logic [DATA_W-1:0] sel_word;
    logic              do_ack;
    logic              do_drop;

    // First requester at or above the pointer, wrapping modulo NREQ
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx   = (int'(ptr_q) + k) % NREQ;
            idx_w = IDX_W'(idx);
            if (!found && bus.req[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    assign owner_nxt = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign sel_word  = bus.wr_data[int'(owner_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = '0;
        data_d  = data_q;
        do_ack  = 1'b0;
        do_drop = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    state_d = GRANT;
                end
            end
`ifdef SYNC32_ARB_LOCK_EN
            GRANT, LOCKED: begin
`else
            GRANT: begin
`endif
                if (bus.req[owner_q]) begin
                    data_d = sel_word;
`ifdef SYNC32_ARB_LOCK_EN
                    if (bus.lock[owner_q]) begin
                        state_d = LOCKED;
                    end else begin
                        do_ack = 1'b1;
                    end
`else
                    do_ack = 1'b1;
`endif
                end else begin
                    do_drop = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion and abandon both release the grant and move the pointer past the owner
        if (do_ack || do_drop) begin
            grant_d = '0;
            ptr_d   = owner_nxt;
            state_d = do_ack ? ACK : IDLE;
        end
        if (do_ack) begin
            ack_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.OutData = data_q;

endmodule

// File: tb/tb_sync32_reg_arbiter.sv
// Self-checking bench for sync32_reg_arbiter: vector table, directed corner cases, random vs reference model.
// Lock scenario compiled in when SYNC32_ARB_LOCK_EN is defined.
module tb_sync32_reg_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sync32_reg_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus();

    sync32_reg_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] word [NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) bus.wr_data[i*DATA_W +: DATA_W] = word[i];
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic        busy;
        logic [1:0]  owner;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [19];

    // Reference model state: phase 0 = free, 1 = owner holds grant, 2 = owner acknowledged
    int          m_phase, m_ptr, m_owner;
    logic [31:0] m_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic [3:0] g, input logic [3:0] a,
                             input logic b, input logic [1:0] o, input logic [31:0] d);
        check({nm, "_grant"}, 32'(bus.grant), 32'(g));
        check({nm, "_ack"},   32'(bus.ack),   32'(a));
        check({nm, "_busy"},  32'(bus.busy),  32'(b));
        check({nm, "_owner"}, 32'(bus.owner), 32'(o));
        check({nm, "_data"},  bus.OutData,    d);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lock(input logic [3:0] v);
`ifdef SYNC32_ARB_LOCK_EN
        bus.lock = v;
`else
        if (v != 4'h0) $display("lock ignored without lock feature");
`endif
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bus.req = '0;
        set_lock(4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_phase = 0; m_ptr = 0; m_owner = 0; m_data = '0;
    endtask

    task automatic model_step(input logic [3:0] rq);
        int  idx;
        bit  hit;
        case (m_phase)
            0: begin
                hit = 0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!hit && rq[idx]) begin
                        hit = 1;
                        m_owner = idx;
                    end
                end
                if (hit) m_phase = 1;
            end
            1: begin
                m_ptr = (m_owner + 1) % NREQ;
                if (rq[m_owner]) begin
                    m_data  = word[m_owner];
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] eg, ea;

        for (int i = 0; i < NREQ; i++) word[i] = 32'h0000_00A0 + 32'(i);
        bus.req = '0;
        set_lock(4'h0);
        do_reset();
        check_all("reset", 4'h0, 4'h0, 1'b0, 2'd0, 32'h0);

        tbl[0]  = '{4'hF, 4'h1, 4'h0, 1'b1, 2'd0, 32'h00};
        tbl[1]  = '{4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 32'hA0};
        tbl[2]  = '{4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 32'hA0};
        tbl[3]  = '{4'hF, 4'h2, 4'h0, 1'b1, 2'd1, 32'hA0};
        tbl[4]  = '{4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 32'hA1};
        tbl[5]  = '{4'hF, 4'h0, 4'h0, 1'b0, 2'd1, 32'hA1};
        tbl[6]  = '{4'hF, 4'h4, 4'h0, 1'b1, 2'd2, 32'hA1};
        tbl[7]  = '{4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 32'hA2};
        tbl[8]  = '{4'hF, 4'h0, 4'h0, 1'b0, 2'd2, 32'hA2};
        tbl[9]  = '{4'hF, 4'h8, 4'h0, 1'b1, 2'd3, 32'hA2};
        tbl[10] = '{4'hF, 4'h0, 4'h8, 1'b1, 2'd3, 32'hA3};
        tbl[11] = '{4'hF, 4'h0, 4'h0, 1'b0, 2'd3, 32'hA3};
        tbl[12] = '{4'h9, 4'h1, 4'h0, 1'b1, 2'd0, 32'hA3};
        tbl[13] = '{4'h9, 4'h0, 4'h1, 1'b1, 2'd0, 32'hA0};
        tbl[14] = '{4'h9, 4'h0, 4'h0, 1'b0, 2'd0, 32'hA0};
        tbl[15] = '{4'h9, 4'h8, 4'h0, 1'b1, 2'd3, 32'hA0};
        tbl[16] = '{4'h9, 4'h0, 4'h8, 1'b1, 2'd3, 32'hA3};
        tbl[17] = '{4'h9, 4'h0, 4'h0, 1'b0, 2'd3, 32'hA3};
        tbl[18] = '{4'h0, 4'h0, 4'h0, 1'b0, 2'd3, 32'hA3};
        for (int i = 0; i < 19; i++) begin
            bus.req = tbl[i].req;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].grant, tbl[i].ack, tbl[i].busy,
                      tbl[i].owner, tbl[i].data);
        end

        // Single write from requester 2 (pointer is 0 here)
        word[2] = 32'h1234_5678;
        bus.req = 4'b0100;
        tick();
        check_all("single_g", 4'b0100, 4'h0, 1'b1, 2'd2, 32'hA3);
        tick();
        check_all("single_a", 4'h0, 4'b0100, 1'b1, 2'd2, 32'h1234_5678);
        bus.req = 4'h0;
        tick();
        check_all("single_i", 4'h0, 4'h0, 1'b0, 2'd2, 32'h1234_5678);

        // Abandon: requester 1 drops during GRANT, pointer moves to 2
        bus.req = 4'b0010;
        tick();
        check_all("aband_g", 4'b0010, 4'h0, 1'b1, 2'd1, 32'h1234_5678);
        bus.req = 4'h0;
        tick();
        check_all("aband_x", 4'h0, 4'h0, 1'b0, 2'd1, 32'h1234_5678);
        bus.req = 4'b0101;
        tick();
        check_all("aband_n", 4'b0100, 4'h0, 1'b1, 2'd2, 32'h1234_5678);
        bus.req = 4'h0;
        tick();
        tick();

        // Asynchronous reset in the middle of a GRANT
        word[1] = 32'hDEAD_BEEF;
        bus.req = 4'b0010;
        tick();
        check_all("rstmid_g", 4'b0010, 4'h0, 1'b1, 2'd1, 32'h1234_5678);
        reset = 1'b0;
        #1;
        check_all("rstmid_r", 4'h0, 4'h0, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        check_all("rstmid_h", 4'h0, 4'h0, 1'b0, 2'd0, 32'h0);
        bus.req = 4'hF;
        reset   = 1'b1;
        tick();
        check_all("rstmid_p", 4'b0001, 4'h0, 1'b1, 2'd0, 32'h0);
        bus.req = 4'h0;
        tick();

`ifdef SYNC32_ARB_LOCK_EN
        do_reset();
        bus.req  = 4'b1001;
        bus.lock = 4'b0001;
        word[0]  = 32'd1;
        tick();
        check_all("lock_g", 4'b0001, 4'h0, 1'b1, 2'd0, 32'h0);
        for (int v = 1; v <= 5; v++) begin
            word[0] = 32'(v);
            tick();
            check_all($sformatf("lock_w%0d", v), 4'b0001, 4'h0, 1'b1, 2'd0, 32'(v));
        end
        bus.lock = 4'h0;
        word[0]  = 32'd6;
        tick();
        check_all("lock_a", 4'h0, 4'b0001, 1'b1, 2'd0, 32'd6);
        bus.req = 4'b1000;
        tick();
        check_all("lock_i", 4'h0, 4'h0, 1'b0, 2'd0, 32'd6);
        tick();
        check_all("lock_n", 4'b1000, 4'h0, 1'b1, 2'd3, 32'd6);
        bus.req = 4'h0;
        tick();
`endif

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            eg = (m_phase == 1) ? (4'b0001 << m_owner) : 4'h0;
            ea = (m_phase == 2) ? (4'b0001 << m_owner) : 4'h0;
            check_all("rnd", eg, ea, (m_phase != 0), 2'(m_owner), m_data);
            rq = bus.req;
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i]) begin
                    if (m_phase == 2 && m_owner == i) rq[i] = 1'b0;
                    else if (m_phase == 1 && m_owner == i && $urandom_range(7) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[i]   = 1'b1;
                    word[i] = $urandom;
                end
            end
            bus.req = rq;
            model_step(rq);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
